// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver with 16x oversampling, 2-FF input sync,
// start-bit glitch rejection and framing-error detection.
module uart_rx_sampler #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int NB_DATA    = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIVISOR - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               tick;
    logic [1:0]         sync;
    logic               rx_s;
    logic [3:0]         s;
    logic [NW-1:0]      n;
    logic [NB_DATA-1:0] shreg;

    // Free-running baud tick, deliberately not phase-locked to the start edge
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], i_rx};
        end
    end

    assign rx_s   = sync[1];
    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            shreg       <= '0;
            o_rx_data   <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == 4'd7) begin
                            s     <= '0;
                            n     <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s     <= '0;
                            shreg <= {rx_s, shreg[NB_DATA-1:1]};
                            if (n == N_LAST) begin
                                state <= STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s == 4'd15) begin
                            s <= '0;
                            if (rx_s) begin
                                o_rx_data <= shreg;
                                o_rx_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                o_frame_err <= 1'b1;
                                state       <= WAIT_HIGH;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                // A held-low line (break) must not look like a new start
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: driver pushes expected
// frames, a monitor pops and checks them on every output pulse.
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       done;
    logic       ferr;
    logic       busy;
    logic [7:0] ddata;
    logic       ddone;
    logic       dferr;
    logic       dbusy;

    always #5 clk = ~clk;

    uart_rx_sampler #(
        .CLK_FREQ(3200),
        .BAUD_RATE(100)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_rx(rx),
        .o_rx_data(data),
        .o_rx_done(done),
        .o_frame_err(ferr),
        .o_busy(busy)
    );

    uart_rx_sampler dut_def (
        .i_clk(clk),
        .i_reset(rst),
        .i_rx(1'b1),
        .o_rx_data(ddata),
        .o_rx_done(ddone),
        .o_frame_err(dferr),
        .o_busy(dbusy)
    );

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         fall;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_done = -1;
    int   prev_done = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor
    always @(posedge clk) begin
        #1;
        if (done && ferr) chk("pulse_overlap", 1, 0);
        if (done || ferr) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind_err", int'(ferr), int'(e.err));
                chk("rx_data", int'(data), int'(e.data));
                chk_rng("latency", cyc - e.fall, 305, 307);
                if (done) chk("busy_at_done", int'(busy), 0);
            end
            if (done) begin
                prev_done = last_done;
                last_done = cyc;
            end
        end
    end

    task automatic drive(input logic b, input int ncyc);
        @(negedge clk);
        rx = b;
        repeat (ncyc - 1) @(negedge clk);
    endtask

    // Full frame; expectation is pushed at the falling start edge
    task automatic send(input logic [7:0] d, input logic stop,
                        input bit err, input logic [7:0] exp_data);
        exp_t x;
        @(negedge clk);
        rx = 1'b0;
        x.err  = err;
        x.data = exp_data;
        x.fall = cyc;
        sb.push_back(x);
        repeat (31) @(negedge clk);
        for (int i = 0; i < 8; i++) drive(d[i], 32);
        drive(stop, 32);
    endtask

    initial begin
        int t[11];
        int nt;
        logic [7:0] pd;
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int tt[11];
        int ntk;
        logic [7:0] part;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_data", int'(data), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ferr", int'(ferr), 0);
        chk("reset_busy", int'(busy), 0);
        drive(1'b1, 20);
        chk("idle_busy", int'(busy), 0);

        // 1: single byte
        send(8'h02, 1'b1, 1'b0, 8'h02);
        drive(1'b1, 10);
        chk("t1_data", int'(data), 8'h02);

        // 2: back-to-back frames with one stop bit
        send(8'hA5, 1'b1, 1'b0, 8'hA5);
        send(8'h00, 1'b1, 1'b0, 8'h00);
        drive(1'b1, 10);
        chk("t2_spacing", last_done - prev_done, 320);
        chk("t2_data", int'(data), 8'h00);

        // 3: short low glitch
        drive(1'b0, 8);
        chk("t3_busy_hi", int'(busy), 1);
        drive(1'b1, 40);
        chk("t3_busy_lo", int'(busy), 0);
        chk("t3_data_held", int'(data), 8'h00);

        // 4: framing error followed by break
        send(8'h3C, 1'b0, 1'b1, 8'h00);
        drive(1'b0, 200);
        chk("t4_busy_break", int'(busy), 1);
        chk("t4_data_held", int'(data), 8'h00);
        @(negedge clk);
        rx = 1'b1;
        @(posedge clk);
        #1 chk("t4_busy_e1", int'(busy), 1);
        @(posedge clk);
        #1 chk("t4_busy_e2", int'(busy), 1);
        @(posedge clk);
        #1 chk("t4_busy_e3", int'(busy), 0);
        drive(1'b1, 20);
        send(8'h55, 1'b1, 1'b0, 8'h55);
        drive(1'b1, 10);
        chk("t4_data", int'(data), 8'h55);

        // 5: reset in the middle of data bit 4
        part = 8'hC3;
        drive(1'b0, 32);
        for (int i = 0; i < 4; i++) drive(part[i], 32);
        drive(part[4], 16);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_data", int'(data), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_ferr", int'(ferr), 0);
        chk("t5_busy", int'(busy), 0);
        drive(1'b1, 40);
        chk("t5_busy_idle", int'(busy), 0);
        send(8'hFF, 1'b1, 1'b0, 8'hFF);
        drive(1'b1, 10);
        chk("t5_data_ff", int'(data), 8'hFF);

        // 6: default-parameter tick period
        ntk = 0;
        for (int k = 0; k < 2200 && ntk < 11; k++) begin
            @(negedge clk);
            if (dut_def.tick) begin
                tt[ntk] = cyc;
                ntk++;
            end
        end
        chk("t6_tick_count", ntk, 11);
        for (int i = 1; i < 11; i++) begin
            if (i < ntk) chk("t6_tick_period", tt[i] - tt[i-1], 162);
        end

        drive(1'b1, 50);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
